// File: rtl/dmac_pkg.sv
// dmac_pkg: types and default sizing shared by the dmac transfer engine.
//   AW_DEF / DW_DEF / CW_DEF : default address, data and count widths
//   TMO_DEF                  : default watchdog limit in cycles
//   xfer_state_e             : 3-bit transfer engine state
//   st_busy()                : true while a memory request is outstanding
package dmac_pkg;

  localparam int unsigned AW_DEF  = 16;
  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned CW_DEF  = 8;
  localparam int unsigned TMO_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } xfer_state_e;

  function automatic logic st_busy(input xfer_state_e s);
    return (s == ST_RD) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/dmac_xfer_wdog.sv
// dmac_xfer_wdog: per-request watchdog for the transfer engine.
//   clk_i    : clock
//   rst_i    : synchronous reset, active-high
//   clr_i    : restart the count at zero (wins over en_i)
//   en_i     : a request is pending this cycle
//   expire_o : pending request is in its last allowed cycle (cycle TMO)
//
// The count is the number of cycles already spent waiting, so expire_o marks
// the TMO-th waiting cycle; an ack in that same cycle is still accepted by
// the engine, a missing ack sends it to the error state on the next edge.
module dmac_xfer_wdog
  import dmac_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned WW = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [WW-1:0] LAST = WW'(TMO - 1);

  logic [WW-1:0] count_q;
  logic [WW-1:0] count_d;

  // Saturates at LAST; the engine leaves the waiting state before it matters.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + WW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/dmac_xfer_engine.sv
// dmac_xfer_engine: word-by-word memory-to-memory copy engine driven by the
// dmac control FSM strobes; one buffered word in flight at a time.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   cfg_load_i, cfg_src_i,
//   cfg_dst_i, cfg_cnt_i          : transfer setup, taken in IDLE only
//   start_i, abort_i, done_clr_i  : control strobes
//   rd_req_o, rd_addr_o,
//   rd_ack_i, rd_data_i           : read handshake
//   wr_req_o, wr_addr_o,
//   wr_data_o, wr_ack_i           : write handshake
//   busy_o                        : request phase in progress
//   xfer_done_o                   : transfer finished (also set on error)
//   xfer_err_o                    : watchdog timeout or abort
//   remaining_o                   : words still to copy
//
// state | meaning
// IDLE  | waiting for configuration / start
// RD    | read request outstanding at src
// WR    | write of buffered word outstanding at dst
// DONE  | copy complete, waiting for done_clr
// ERR   | aborted or timed out, src/dst/cnt frozen, waiting for done_clr
module dmac_xfer_engine
  import dmac_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_load_i,
  input  logic [AW-1:0] cfg_src_i,
  input  logic [AW-1:0] cfg_dst_i,
  input  logic [CW-1:0] cfg_cnt_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          done_clr_i,
  output logic          rd_req_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic          rd_ack_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          wr_req_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  input  logic          wr_ack_i,
  output logic          busy_o,
  output logic          xfer_done_o,
  output logic          xfer_err_o,
  output logic [CW-1:0] remaining_o
);

  xfer_state_e   state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;

  logic          ld_idle;
  logic [CW-1:0] cnt_eff;
  logic          rd_fire;
  logic          wr_fire;
  logic          wdog_clr;
  logic          wdog_en;
  logic          wdog_expire;

  // A load coincident with start must already steer the zero-length decision.
  assign ld_idle = (state_q == ST_IDLE) && cfg_load_i;
  assign cnt_eff = ld_idle ? cfg_cnt_i : cnt_q;

  // abort beats an ack in the same cycle, so the handshake does not complete.
  assign rd_fire = (state_q == ST_RD) && rd_ack_i && !abort_i;
  assign wr_fire = (state_q == ST_WR) && wr_ack_i && !abort_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (cnt_eff == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        if (abort_i) begin
          state_d = ST_ERR;
        end else if (rd_ack_i) begin
          state_d = ST_WR;
        end else if (wdog_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_WR: begin
        if (abort_i) begin
          state_d = ST_ERR;
        end else if (wr_ack_i) begin
          state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_RD;
        end else if (wdog_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (done_clr_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req_o    = (state_q == ST_RD);
    wr_req_o    = (state_q == ST_WR);
    busy_o      = st_busy(state_q);
    xfer_done_o = (state_q == ST_DONE) || (state_q == ST_ERR);
    xfer_err_o  = (state_q == ST_ERR);
  end

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (ld_idle) begin
      src_d = cfg_src_i;
      dst_d = cfg_dst_i;
      cnt_d = cfg_cnt_i;
    end
    if (rd_fire) begin
      buf_d = rd_data_i;
      src_d = src_q + AW'(1);
    end
    if (wr_fire) begin
      dst_d = dst_q + AW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  // Restart the watchdog whenever a new request phase begins or an ack lands.
  assign wdog_en  = st_busy(state_q);
  assign wdog_clr = (state_d != state_q) || rd_fire || wr_fire;

  dmac_xfer_wdog #(
    .TMO(TMO)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (wdog_clr),
    .en_i    (wdog_en),
    .expire_o(wdog_expire)
  );

  assign rd_addr_o   = src_q;
  assign wr_addr_o   = dst_q;
  assign wr_data_o   = buf_q;
  assign remaining_o = cnt_q;

endmodule

// File: doc/dmac_xfer_engine.md
Name: dmac_xfer_engine

Overview:
- Datapath stage directly downstream of the dmac control FSM.
- Takes decoded control strobes (configure, start, abort, done-clear) from the FSM outputs and performs the word-by-word memory-to-memory copy.
- Returns the level status `xfer_done`, which drives the FSM's x8 "transfer complete" condition input.
- Single-word buffered read/write handshake engine with per-request watchdog timeout.

Parameters:
- AW, 16, address width (bits)
- DW, 8, data word width (bits)
- CW, 8, transfer count width (bits)
- TMO, 15, max cycles to wait for an ack before error (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_load  in  1  load src/dst/count from cfg_* (honoured in IDLE only)
- cfg_src  in  AW  source start address
- cfg_dst  in  AW  destination start address
- cfg_cnt  in  CW  number of words to copy
- start  in  1  begin transfer (honoured in IDLE only)
- abort  in  1  cancel transfer
- done_clr  in  1  clear xfer_done/xfer_err, return to IDLE
- rd_req  out  1  read request
- rd_addr  out  AW  read address
- rd_ack  in  1  read accepted, rd_data valid this cycle
- rd_data  in  DW  read data
- wr_req  out  1  write request
- wr_addr  out  AW  write address
- wr_data  out  DW  write data
- wr_ack  in  1  write accepted
- busy  out  1  high in RD or WR
- xfer_done  out  1  level, transfer finished (to FSM x8)
- xfer_err  out  1  level, watchdog timeout or abort occurred
- remaining  out  CW  words still to copy

Behaviour:
- Reset (synchronous, clk edge with rst=1): state=IDLE; src, dst, cnt, buf = 0; watchdog = 0; all outputs 0.
- rst has priority over every other input, including mid-transfer; the in-flight request is dropped.
- States: IDLE, RD, WR, DONE, ERR. The state is encoded as a 3-bit enum.
- IDLE:
  - cfg_load=1 latches cfg_src/cfg_dst/cfg_cnt next edge.
  - start=1 with cnt!=0: go to RD.
  - start=1 with cnt==0: go directly to DONE (zero-length transfer).
  - cfg_load and start in the same cycle: the newly loaded values are used.
- RD:
  - rd_req=1 and rd_addr=src, combinationally from state.
  - On rd_ack: buf<=rd_data, src<=src+1 (mod 2^AW), go to WR.
  - Minimum latency is one cycle per handshake phase. An ack in the first RD cycle is legal.
- WR:
  - wr_req=1, wr_addr=dst, wr_data=buf.
  - On wr_ack: dst<=dst+1 (mod 2^AW), cnt<=cnt-1.
  - If cnt==1 before the decrement, go to DONE; otherwise go to RD.
- Throughput: 2 cycles per word with zero-wait acks. A 4-word copy with immediate acks reaches DONE 8 cycles after start.
- DONE: xfer_done=1, held until done_clr=1, then IDLE. start and cfg_load are ignored in DONE.
- ERR: xfer_err=1, xfer_done=1 (so the FSM's x8 wait releases), held until done_clr, then IDLE. src/dst/cnt are frozen for debug.
- Watchdog:
  - Cleared on entry to RD/WR and on each ack; increments every cycle the request is pending.
  - When the count reaches TMO without an ack, go to ERR.
  - An ack arriving on the TMO cycle wins; no error is raised.
- abort:
  - In RD/WR: go to ERR next edge. abort beats a coincident ack; no address/count update.
  - In IDLE/DONE/ERR: no effect.
- rd_ack in a state other than RD and wr_ack in a state other than WR are ignored.
- remaining = cnt at all times. busy = (state==RD or state==WR).
- Outputs rd_req/wr_req/busy/xfer_done/xfer_err decode from state only; no input-to-output combinational path.

Decomposition:
- Shared package dmac_pkg:
  - state enum type for this engine
  - default widths AW/DW/CW
  - TMO default constant
- One natural sub-module, dmac_xfer_wdog: resettable up-counter with clear/enable, expiry output at TMO.
- Address/count registers and the FSM stay in the top module.

Test Plan:
- Basic copy: load src=0x0100, dst=0x0200, cnt=3, start; memory model acks immediately with data A1,B2,C3 -> writes 0x0200=A1, 0x0201=B2, 0x0202=C3; xfer_done rises 6 cycles after start; remaining=0; done_clr returns busy=0, xfer_done=0.
- Wrap and wait states: src=0xFFFF, dst=0xFFFE, cnt=3, acks delayed 2 cycles -> read addresses FFFF,0000,0001; write addresses FFFE,FFFF,0000; no xfer_err.
- Zero length: cnt=0, start -> DONE next edge; rd_req and wr_req never asserted; xfer_done=1.
- Timeout: TMO=15, rd_ack held low -> xfer_err=1 and xfer_done=1 exactly 15 cycles after rd_req rises. Repeat with the ack on cycle 15 -> no error, transfer proceeds.
- Abort vs ack: abort and wr_ack in the same cycle of word 2 of 4 -> ERR; remaining=3, dst not incremented.
- Reset and config: rst asserted mid-WR -> all outputs 0 next edge, state IDLE. cfg_load while busy -> ignored; remaining is unchanged.
